pio_gpio_n: RTL
===============

# pio_gpio_n

Parametrised Avalon-MM GPIO controller, successor to the fixed 32-pin PIO block. Drives up to 32 tri-state pins with per-pin output enable, atomic set/clear/toggle, synchronised pin readback and per-pin rising/falling edge capture with a maskable level interrupt. Sits on the Qsys system bus as a memory-mapped slave; pins go to top-level conduit.

## Interface
- WIDTH, 32, number of pins (1..32); register bits >= WIDTH read 0, writes ignored
- SYNC_STAGES, 2, input synchroniser depth (2..4)
- RESET_OUT, 0, reset value of DATA_OUT (WIDTH bits)
- RESET_OE, 0, reset value of OUT_EN (WIDTH bits)

- csi_MCLK_clk  in  1  system clock; one clock, all logic on rising edge
- rsi_MRST_reset  in  1  reset, synchronous, active-high
- avs_gpio_address  in  4  word address
- avs_gpio_writedata  in  32  write data
- avs_gpio_byteenable  in  4  byte lanes for writes
- avs_gpio_write  in  1  write strobe
- avs_gpio_read  in  1  read strobe
- avs_gpio_readdata  out  32  registered read data
- avs_gpio_waitrequest  out  1  tied 0
- coe_gpio  inout  WIDTH  pins; bit i = DATA_OUT[i] when OUT_EN[i] else Z
- ins_irq  out  1  level interrupt, registered

## Operation
- Register map (word address):
  - 0 DATA_OUT RW; 1 OUT_EN RW; 2 PIN_IN RO (synchronised pins)
  - 3 SET WO: DATA_OUT |= wd; 4 CLR WO: DATA_OUT &= ~wd; 5 TOGGLE WO: DATA_OUT ^= wd
  - 6 IRQ_MASK RW; 7 EDGE_CAP RW1C; 8 RISE_EN RW; 9 FALL_EN RW
  - 10 INFO RO: {16'h5049, 8'(SYNC_STAGES), 8'(WIDTH)}
  - 11..15 unmapped: read 0, write ignored; WO registers read 0
- Byteenable: every write (RW, WO, W1C) affects only bits in enabled lanes; other bits unchanged.
- Input path: SYNC_STAGES flop chain per pin -> PIN_IN; one further flop PIN_PREV.
- Edge capture: EDGE_CAP[i] set when RISE_EN[i] & PIN_IN[i] & ~PIN_PREV[i], or FALL_EN[i] & ~PIN_IN[i] & PIN_PREV[i]. Sticky until W1C.
- Simultaneous capture and W1C on same bit same cycle: set wins (bit stays 1).
- ins_irq <= |(EDGE_CAP & IRQ_MASK), registered.
- Output-enabled pins read back their driven value through the synchroniser.
- Reset: DATA_OUT=RESET_OUT, OUT_EN=RESET_OE, IRQ_MASK/EDGE_CAP/RISE_EN/FALL_EN=0, sync chain and PIN_PREV=0, avs_gpio_readdata=0, ins_irq=0. No edge captured on the first cycles after reset because RISE_EN/FALL_EN=0.
- Reset asserted mid-access: access discarded, all state reset on that edge.

## Timing
- Zero wait states; write accepted in the cycle avs_gpio_write=1; register updated at that clock edge; pin changes visible on coe_gpio from the next cycle.
- Read latency fixed 1: readdata updated on the edge where avs_gpio_read=1, valid the following cycle; holds until next read; read with no strobe leaves readdata unchanged.
- Read and write same address same cycle: read returns pre-write value.
- Pin toggle at cycle T: PIN_IN reflects it after SYNC_STAGES edges; EDGE_CAP set at T+SYNC_STAGES+1; ins_irq high at T+SYNC_STAGES+2.
- W1C clearing last masked bit at cycle T: ins_irq low at T+2.
- Pulses shorter than one clock may be missed; no guarantee.

## Test plan
- Reset, WIDTH=32: read addr 0/1/6/7 -> 0; read addr 10 -> 32'h50490220; all pins Z.
- Write OUT_EN=32'hFFFF_FFFF, DATA_OUT=32'h0000_00F0; SET 32'h0000_0001; CLR 32'h0000_0010; TOGGLE 32'h8000_0000 -> pins = 32'h8000_00E1, DATA_OUT read = same.
- Write DATA_OUT=32'hAABBCCDD then byteenable 4'b0010 write 32'h11223344 -> DATA_OUT=32'hAABB33DD.
- OUT_EN=0, RISE_EN[3]=1, IRQ_MASK[3]=1; drive pin3 0->1 at T -> EDGE_CAP=32'h8 at T+3, ins_irq=1 at T+4; falling edge on pin3 -> no change; W1C 32'h8 -> ins_irq=0 two cycles later.
- W1C of EDGE_CAP bit in same cycle a new edge captures it -> bit reads 1, ins_irq stays high.
- WIDTH=8, SYNC_STAGES=3: write 32'hFFFF_FFFF to DATA_OUT -> reads 32'h0000_00FF; INFO = 32'h50490308; edge latency T+4.

Source files
------------

// File: rtl/pio_gpio_n.sv
// pio_gpio_n: Avalon-MM GPIO slave with per-pin output enable and atomic
// set/clear/toggle. Pins pass through a synchroniser before readback.
// Rising and falling edges are captured per pin into a sticky register,
// and a masked interrupt is driven from those captured edges.
module pio_gpio_n #(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_OE    = '0
) (
    input  logic              csi_MCLK_clk,
    input  logic              rsi_MRST_reset,
    input  logic [3:0]        avs_gpio_address,
    input  logic [31:0]       avs_gpio_writedata,
    input  logic [3:0]        avs_gpio_byteenable,
    input  logic              avs_gpio_write,
    input  logic              avs_gpio_read,
    output logic [31:0]       avs_gpio_readdata,
    output logic              avs_gpio_waitrequest,
    inout  wire  [WIDTH-1:0]  coe_gpio,
    output logic              ins_irq
);

    localparam logic [3:0] A_DATA = 4'd0, A_OE   = 4'd1, A_PIN  = 4'd2,
                           A_SET  = 4'd3, A_CLR  = 4'd4, A_TOG  = 4'd5,
                           A_MASK = 4'd6, A_CAP  = 4'd7, A_RISE = 4'd8,
                           A_FALL = 4'd9, A_INFO = 4'd10;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] out_en_q,   out_en_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] rise_en_q,  rise_en_d;
    logic [WIDTH-1:0] fall_en_q,  fall_en_d;
    logic [WIDTH-1:0] pin_prev_q, pin_prev_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] pin_in;
    logic [WIDTH-1:0] rise_hit;
    logic [WIDTH-1:0] fall_hit;

    assign avs_gpio_readdata    = readdata_q;
    assign avs_gpio_waitrequest = 1'b0;
    assign ins_irq              = irq_q;

    // Per-pin tri-state driver: drive only where the output enable is set.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign coe_gpio[i] = out_en_q[i] ? data_out_q[i] : 1'bz;
    end

    // Next-state: bus writes (byte-lane masked), synchroniser, edge capture, read mux.
    always_comb begin
        lane_mask = {{8{avs_gpio_byteenable[3]}}, {8{avs_gpio_byteenable[2]}},
                     {8{avs_gpio_byteenable[1]}}, {8{avs_gpio_byteenable[0]}}};
        wmask     = lane_mask[WIDTH-1:0];
        wbits     = avs_gpio_writedata[WIDTH-1:0] & wmask;
        pin_in    = sync_q[SYNC_STAGES-1];
        rise_hit  = rise_en_q & pin_in & ~pin_prev_q;
        fall_hit  = fall_en_q & ~pin_in & pin_prev_q;

        data_out_d = data_out_q;
        out_en_d   = out_en_q;
        irq_mask_d = irq_mask_q;
        edge_cap_d = edge_cap_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        readdata_d = readdata_q;

        sync_d[0] = coe_gpio;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        pin_prev_d = pin_in;

        if (avs_gpio_write) begin
            case (avs_gpio_address)
                A_DATA:  data_out_d = (data_out_q & ~wmask) | wbits;
                A_OE:    out_en_d   = (out_en_q   & ~wmask) | wbits;
                A_SET:   data_out_d = data_out_q | wbits;
                A_CLR:   data_out_d = data_out_q & ~wbits;
                A_TOG:   data_out_d = data_out_q ^ wbits;
                A_MASK:  irq_mask_d = (irq_mask_q & ~wmask) | wbits;
                A_CAP:   edge_cap_d = edge_cap_q & ~wbits;
                A_RISE:  rise_en_d  = (rise_en_q  & ~wmask) | wbits;
                A_FALL:  fall_en_d  = (fall_en_q  & ~wmask) | wbits;
                default: ;
            endcase
        end

        // A fresh edge overrides a same-cycle write-one-to-clear.
        edge_cap_d = edge_cap_d | rise_hit | fall_hit;

        irq_d = |(edge_cap_q & irq_mask_q);

        // Read mux samples the pre-write register values.
        if (avs_gpio_read) begin
            case (avs_gpio_address)
                A_DATA:  readdata_d = 32'(data_out_q);
                A_OE:    readdata_d = 32'(out_en_q);
                A_PIN:   readdata_d = 32'(pin_in);
                A_MASK:  readdata_d = 32'(irq_mask_q);
                A_CAP:   readdata_d = 32'(edge_cap_q);
                A_RISE:  readdata_d = 32'(rise_en_q);
                A_FALL:  readdata_d = 32'(fall_en_q);
                A_INFO:  readdata_d = {16'h5049, 8'(SYNC_STAGES), 8'(WIDTH)};
                default: readdata_d = 32'h0;
            endcase
        end
    end

    // State registers with synchronous reset; reset discards any in-flight access.
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            data_out_q <= RESET_OUT;
            out_en_q   <= RESET_OE;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            pin_prev_q <= '0;
            sync_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            out_en_q   <= out_en_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            pin_prev_q <= pin_prev_d;
            sync_q     <= sync_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

endmodule
